// File: rtl/mic_scan_pkg.sv
// Shared types for the mic scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mic_scan_pkg;

    localparam int CNT_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_STORE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/edge_gate_counter.sv
// Synchronised falling-edge counter with hold-at-zero clear and saturation.
// Latency: input edge reaches count 3 clocks later (2-FF sync + count register).
// Backpressure: none; counts only while en is high.
module edge_gate_counter
    import mic_scan_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             track,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic sync1;
    logic sync2;
    logic prev;
    logic fall;

    assign fall = prev & ~sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            count <= '0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
            // prev follows the line while settling so a mux switch never looks like an edge
            if (track || en) prev <= sync2;
            if (clr) begin
                count <= '0;
            end else if (en && fall && (count != {CNT_W{1'b1}})) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mic_scan_controller.sv
// Sweeps one gated edge counter across NUM_CH mic inputs and reports the strongest in-band channel.
// Latency: sweep takes NUM_CH*(SETTLE_CYCLES+GATE_CYCLES+1)+1 clocks from start accept to done.
// Backpressure: none; start is ignored while busy.
module mic_scan_controller
    import mic_scan_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int GATE_CYCLES   = 100_000_000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int F_LO          = 400,
    parameter int F_HI          = 600
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [NUM_CH-1:0]         mic_in,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic [NUM_CH*CNT_W-1:0]   hz_ch,
    output logic [NUM_CH-1:0]         in_band,
    output logic [$clog2(NUM_CH)-1:0] best_ch,
    output logic                      best_valid
);

    localparam int SEL_W   = $clog2(NUM_CH);
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);

    state_t             state;
    state_t             state_nx;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   hz_r [NUM_CH];
    logic [CNT_W-1:0]   cnt;
    logic               cnt_en;
    logic               cnt_track;
    logic [NUM_CH-1:0]  band_nx;
    logic [SEL_W-1:0]   best_nx;
    logic [CNT_W-1:0]   best_cnt;
    logic               found;

    edge_gate_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (mic_in[ch_sel]),
        .track (cnt_track),
        .en    (cnt_en),
        .clr   (cnt_track),
        .count (cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_SETTLE;
            ST_SETTLE:  if (timer == '0) state_nx = ST_MEASURE;
            ST_MEASURE: if (timer == '0) state_nx = ST_STORE;
            ST_STORE:   state_nx = (ch_sel == LAST_CH) ? ST_DONE : ST_SETTLE;
            ST_DONE:    state_nx = continuous ? ST_SETTLE : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        cnt_en    = (state == ST_MEASURE);
        cnt_track = (state == ST_SETTLE);
    end

    // One down-counter serves both windows; it is reloaded on entry to each timed state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state_nx == ST_SETTLE && state != ST_SETTLE) begin
            timer <= SETTLE_LD;
        end else if (state_nx == ST_MEASURE && state != ST_MEASURE) begin
            timer <= GATE_LD;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_sel <= '0;
        end else if ((state == ST_IDLE && start) || (state == ST_DONE && continuous)) begin
            ch_sel <= '0;
        end else if (state == ST_STORE && ch_sel != LAST_CH) begin
            ch_sel <= ch_sel + 1'b1;
        end
    end

    always_comb begin
        band_nx  = '0;
        best_nx  = '0;
        best_cnt = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            band_nx[i] = (32'(hz_r[i]) >= F_LO) && (32'(hz_r[i]) <= F_HI);
            // strict compare keeps the lowest index on ties
            if (band_nx[i] && (!found || hz_r[i] > best_cnt)) begin
                found    = 1'b1;
                best_cnt = hz_r[i];
                best_nx  = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) hz_r[i] <= '0;
            in_band    <= '0;
            best_ch    <= '0;
            best_valid <= 1'b0;
        end else begin
            if (state == ST_STORE) hz_r[ch_sel] <= cnt;
            if (state == ST_DONE) begin
                in_band    <= band_nx;
                best_ch    <= best_nx;
                best_valid <= |band_nx;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign hz_ch[g*CNT_W +: CNT_W] = hz_r[g];
    end

endmodule

// File: tb/tb_mic_scan_controller.sv
// Directed bench for mic_scan_controller: two instances (10-bit and 8-bit counts) share stimulus.
// Latency: n/a.  Backpressure: n/a.
module tb_mic_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [2:0]  mic_in;
    logic        busy, done, best_valid;
    logic [1:0]  ch_sel, best_ch;
    logic [29:0] hz_ch;
    logic [2:0]  in_band;
    logic        busy8, done8, best_valid8;
    logic [1:0]  ch_sel8, best_ch8;
    logic [23:0] hz_ch8;
    logic [2:0]  in_band8;

    int errors = 0;
    int checks = 0;

    // stimulus generator state
    int mode = 0;
    int per [3] = '{20, 25, 50};
    int ph [3] = '{0, 0, 0};
    int burst_n [3] = '{0, 0, 0};
    logic [2:0] lvl = 3'b000;
    int gcyc = 0;
    int t0 = 0;

    mic_scan_controller #(
        .NUM_CH(3), .CNT_W(10), .GATE_CYCLES(1000), .SETTLE_CYCLES(10), .F_LO(40), .F_HI(60)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .mic_in(mic_in),
        .busy(busy), .done(done), .ch_sel(ch_sel), .hz_ch(hz_ch), .in_band(in_band),
        .best_ch(best_ch), .best_valid(best_valid)
    );

    mic_scan_controller #(
        .NUM_CH(3), .CNT_W(8), .GATE_CYCLES(1000), .SETTLE_CYCLES(10), .F_LO(40), .F_HI(60)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .mic_in(mic_in),
        .busy(busy8), .done(done8), .ch_sel(ch_sel8), .hz_ch(hz_ch8), .in_band(in_band8),
        .best_ch(best_ch8), .best_valid(best_valid8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        gcyc++;
    end

    // mode 0: free-running square waves (per==0 -> constant lvl); mode 2: bursts of
    // burst_n[k] falling edges (period 10) placed inside channel k's gate window
    initial begin
        mic_in = 3'b000;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (mode == 2) begin
                    int rel, j, off;
                    rel = gcyc - t0;
                    j   = rel / 1011;
                    off = rel % 1011;
                    mic_in[k] = !(j == k && off >= 100 && off < 100 + 10 * burst_n[k]
                                  && ((off - 100) % 10) >= 5);
                end else if (per[k] == 0) begin
                    mic_in[k] = lvl[k];
                end else begin
                    ph[k] = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
                    mic_in[k] = (ph[k] < per[k] / 2);
                end
            end
        end
    end

    task automatic wait_done(input int n0, output int lat);
        lat = -1;
        for (int n = n0 + 1; n <= 4000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // starts a sweep, returns cycles from accept to done, then steps one cycle so results are settled
    task automatic run_sweep(output int lat);
        @(negedge clk);
        t0 = gcyc;
        start = 1'b1;
        wait_done(0, lat);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done); end
        if (ch_sel !== 2'd0) begin errors++; $display("FAIL reset_chsel: got %0d want 0", ch_sel); end
        if (hz_ch !== 30'd0 || in_band !== 3'd0) begin errors++; $display("FAIL reset_res: hz=%h band=%b want 0", hz_ch, in_band); end
        if (best_ch !== 2'd0 || best_valid !== 1'b0) begin errors++; $display("FAIL reset_best: ch=%0d v=%b want 0 0", best_ch, best_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        mode = 0; per = '{20, 25, 50};
        run_sweep(lat);
        checks += 6;
        if (lat !== 3034) begin errors++; $display("FAIL basic_latency: got %0d want 3034", lat); end
        if (hz_ch[9:0] !== 10'd50) begin errors++; $display("FAIL basic_hz0: got %0d want 50", hz_ch[9:0]); end
        if (hz_ch[19:10] !== 10'd40) begin errors++; $display("FAIL basic_hz1: got %0d want 40", hz_ch[19:10]); end
        if (hz_ch[29:20] !== 10'd20) begin errors++; $display("FAIL basic_hz2: got %0d want 20", hz_ch[29:20]); end
        if (in_band !== 3'b011) begin errors++; $display("FAIL basic_band: got %b want 011", in_band); end
        if (best_ch !== 2'd0 || best_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_best: ch=%0d v=%b busy=%b want 0 1 0", best_ch, best_valid, busy);
        end
    endtask

    task automatic test_silent;
        int lat;
        logic [2:0] levels [2] = '{3'b000, 3'b010};
        mode = 0; per = '{20, 0, 20};
        for (int r = 0; r < 2; r++) begin
            lvl = levels[r];
            run_sweep(lat);
            checks += 4;
            if (hz_ch[19:10] !== 10'd0) begin errors++; $display("FAIL silent_hz1[%0d]: got %0d want 0", r, hz_ch[19:10]); end
            if (hz_ch[9:0] !== 10'd50) begin errors++; $display("FAIL silent_hz0[%0d]: got %0d want 50", r, hz_ch[9:0]); end
            if (hz_ch[29:20] !== 10'd50) begin errors++; $display("FAIL silent_hz2[%0d]: got %0d want 50", r, hz_ch[29:20]); end
            if (in_band !== 3'b101 || best_ch !== 2'd0) begin
                errors++; $display("FAIL silent_band[%0d]: band=%b best=%0d want 101 0", r, in_band, best_ch);
            end
        end
    endtask

    task automatic test_saturate;
        int lat;
        mode = 0; per = '{20, 25, 2};
        run_sweep(lat);
        checks += 4;
        if (hz_ch8[23:16] !== 8'd255) begin errors++; $display("FAIL sat_hz2_8bit: got %0d want 255", hz_ch8[23:16]); end
        if (hz_ch[29:20] !== 10'd500) begin errors++; $display("FAIL sat_hz2_10bit: got %0d want 500", hz_ch[29:20]); end
        if (hz_ch8[7:0] !== 8'd50) begin errors++; $display("FAIL sat_hz0_8bit: got %0d want 50", hz_ch8[7:0]); end
        if (in_band8 !== 3'b011 || best_valid8 !== 1'b1) begin
            errors++; $display("FAIL sat_band_8bit: band=%b v=%b want 011 1", in_band8, best_valid8);
        end
    endtask

    task automatic test_best;
        int lat;
        mode = 2; burst_n = '{30, 45, 45};
        run_sweep(lat);
        checks += 3;
        if (hz_ch[19:10] !== 10'd45 || hz_ch[29:20] !== 10'd45 || hz_ch[9:0] !== 10'd30) begin
            errors++; $display("FAIL tie_hz: got %0d %0d %0d want 30 45 45", hz_ch[9:0], hz_ch[19:10], hz_ch[29:20]);
        end
        if (in_band !== 3'b110) begin errors++; $display("FAIL tie_band: got %b want 110", in_band); end
        if (best_ch !== 2'd1 || best_valid !== 1'b1) begin errors++; $display("FAIL tie_best: ch=%0d v=%b want 1 1", best_ch, best_valid); end
        burst_n = '{70, 70, 70};
        run_sweep(lat);
        checks += 3;
        if (hz_ch[9:0] !== 10'd70) begin errors++; $display("FAIL empty_hz0: got %0d want 70", hz_ch[9:0]); end
        if (in_band !== 3'b000) begin errors++; $display("FAIL empty_band: got %b want 000", in_band); end
        if (best_ch !== 2'd0 || best_valid !== 1'b0) begin errors++; $display("FAIL empty_best: ch=%0d v=%b want 0 0", best_ch, best_valid); end
        mode = 0;
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        int first = -1;
        logic mid_busy = 1'b0;
        mode = 0; per = '{20, 25, 50};
        @(negedge clk);
        t0 = gcyc;
        start = 1'b1;
        for (int n = 1; n <= 3100; n++) begin
            @(negedge clk);
            start = (n < 3000 && (n % 100) == 50);
            if (n == 1500) mid_busy = busy;
            if (done) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        start = 1'b0;
        checks += 3;
        if (dones !== 1) begin errors++; $display("FAIL restart_dones: got %0d want 1", dones); end
        if (first !== 3034) begin errors++; $display("FAIL restart_latency: got %0d want 3034", first); end
        if (mid_busy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL restart_busy: mid=%b end=%b want 1 0", mid_busy, busy); end
    endtask

    task automatic test_continuous;
        int lat1, lat2;
        mode = 0; per = '{20, 25, 50};
        continuous = 1'b1;
        @(negedge clk);
        t0 = gcyc;
        start = 1'b1;
        wait_done(0, lat1);
        @(negedge clk);
        checks += 3;
        if (lat1 !== 3034) begin errors++; $display("FAIL cont_latency1: got %0d want 3034", lat1); end
        if (busy !== 1'b1 || done !== 1'b0 || ch_sel !== 2'd0) begin
            errors++; $display("FAIL cont_restart: busy=%b done=%b ch=%0d want 1 0 0", busy, done, ch_sel);
        end
        continuous = 1'b0;
        wait_done(1, lat2);
        if (lat2 !== 3034) begin errors++; $display("FAIL cont_latency2: got %0d want 3034", lat2); end
        @(negedge clk);
        checks += 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat;
        mode = 0; per = '{20, 25, 50};
        @(negedge clk);
        t0 = gcyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1510) @(negedge clk);
        checks += 1;
        if (ch_sel !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: ch=%0d busy=%b want 1 1", ch_sel, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0 || done !== 1'b0 || ch_sel !== 2'd0) begin
            errors++; $display("FAIL midrst_ctl: busy=%b done=%b ch=%0d want 0 0 0", busy, done, ch_sel);
        end
        if (hz_ch !== 30'd0 || in_band !== 3'd0 || best_ch !== 2'd0 || best_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_res: hz=%h band=%b best=%0d v=%b want 0", hz_ch, in_band, best_ch, best_valid);
        end
        if (busy8 !== 1'b0 || done8 !== 1'b0 || ch_sel8 !== 2'd0 || hz_ch8 !== 24'd0 || best_ch8 !== 2'd0) begin
            errors++; $display("FAIL midrst_8bit: busy=%b done=%b ch=%0d hz=%h best=%0d want 0", busy8, done8, ch_sel8, hz_ch8, best_ch8);
        end
        rst_n = 1'b1;
        run_sweep(lat);
        checks += 2;
        if (lat !== 3034) begin errors++; $display("FAIL midrst_latency: got %0d want 3034", lat); end
        if (hz_ch[9:0] !== 10'd50 || hz_ch[19:10] !== 10'd40 || hz_ch[29:20] !== 10'd20 || best_ch !== 2'd0) begin
            errors++; $display("FAIL midrst_sweep: hz=%0d %0d %0d best=%0d want 50 40 20 0",
                               hz_ch[9:0], hz_ch[19:10], hz_ch[29:20], best_ch);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        test_reset();
        test_basic();
        test_silent();
        test_saturate();
        test_best();
        test_start_ignored();
        test_continuous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
